// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the width-changing FIFO family (widening and
// shrinking variants). Holds the ratio helpers and the lane-order constant.
// Both FIFOs use the same lane order, so a shrink followed by a widen
// reproduces the original wide word.
//   shrink_f      : number of narrow lanes per wide word (DWI/DWO)
//   shrink_bit_f  : log2 of that ratio (lane-index width)
//   lane_phys_f   : maps a logical lane (read order) to its bit-slice index
// ---------------------------------------------------------------------------
package fifo_pkg;

    // Lane 0 (least-significant slice) is transferred first.
    localparam bit LANE_LSB_FIRST = 1'b1;

    function automatic int shrink_f(input int dwi, input int dwo);
        return dwi / dwo;
    endfunction

    function automatic int shrink_bit_f(input int dwi, input int dwo);
        return $clog2(dwi / dwo);
    endfunction

    function automatic int lane_phys_f(input int lane, input int shrink);
        return LANE_LSB_FIRST ? lane : (shrink - 1 - lane);
    endfunction

endpackage : fifo_pkg

// File: rtl/ramdp_shrink.sv
// ---------------------------------------------------------------------------
// ramdp_shrink
// Single-clock dual-port RAM: wide write port, narrow registered read port.
// The read address carries the word index in its upper bits and the lane
// index in its low SHRINK_BIT bits; the lane mux sits in front of the
// output register.
//   clk    : clock for both ports
//   rstn   : synchronous active-low reset (clears the read register only)
//   we     : write enable
//   waddr  : wide-word write address (AWI bits)
//   wdata  : wide write data (DWI bits)
//   re     : read enable; rdata holds when low
//   raddr  : narrow-unit read address (AWO bits)
//   rdata  : registered narrow read data (DWO bits)
// ---------------------------------------------------------------------------
module ramdp_shrink
    import fifo_pkg::*;
#(
    parameter int AWI = 3,
    parameter int AWO = 5,
    parameter int DWI = 16,
    parameter int DWO = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           we,
    input  logic [AWI-1:0] waddr,
    input  logic [DWI-1:0] wdata,
    input  logic           re,
    input  logic [AWO-1:0] raddr,
    output logic [DWO-1:0] rdata
);

    localparam int SHRINK     = shrink_f(DWI, DWO);
    localparam int SHRINK_BIT = shrink_bit_f(DWI, DWO);

    // Storage is never reset; stale contents are unreachable once the
    // pointers are cleared.
    logic [DWI-1:0] mem_q [2**AWI];
    logic [DWI-1:0] word_sel;
    logic [DWO-1:0] lane_sel;
    logic [DWO-1:0] rdata_q;
    logic [DWO-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        word_sel = mem_q[raddr[AWO-1:SHRINK_BIT]];
        lane_sel = word_sel[lane_phys_f(int'(raddr[SHRINK_BIT-1:0]), SHRINK)*DWO +: DWO];
        rdata_d  = re ? lane_sel : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule : ramdp_shrink

// File: rtl/fifo_shrink_sync.sv
// ---------------------------------------------------------------------------
// fifo_shrink_sync
// Single-clock FIFO with width reduction: DWI-bit words in, DWO-bit units
// out, least-significant lane first. Status flags are combinational from
// the registered binary pointers.
//   clk        : clock
//   rstn       : synchronous active-low reset
//   winc       : write request (dropped while wfull)
//   wdata      : wide write data
//   rinc       : read request (dropped while rempty)
//   rdata      : registered narrow read data, valid the cycle after a pop
//   wfull      : fewer than SHRINK free narrow slots (no room for a word)
//   rempty     : no narrow unit stored
//   prog_empty : stored units <= PROG_EMPTY_DEPTH
//   count      : stored narrow units, 0..2^AWO
// AWO must equal AWI + log2(DWI/DWO); DWI must be a power-of-two multiple
// (>= 2x) of DWO.
// ---------------------------------------------------------------------------
module fifo_shrink_sync
    import fifo_pkg::*;
#(
    parameter int AWI              = 3,
    parameter int AWO              = 5,
    parameter int DWI              = 16,
    parameter int DWO              = 4,
    parameter int PROG_EMPTY_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           winc,
    input  logic [DWI-1:0] wdata,
    input  logic           rinc,
    output logic [DWO-1:0] rdata,
    output logic           wfull,
    output logic           rempty,
    output logic           prog_empty,
    output logic [AWO:0]   count
);

    localparam int SHRINK     = shrink_f(DWI, DWO);
    localparam int SHRINK_BIT = shrink_bit_f(DWI, DWO);

    localparam logic [AWO:0] FULL_LIM = (AWO+1)'((1 << AWO) - SHRINK);
    localparam logic [AWO:0] PE_LIM   = (AWO+1)'(PROG_EMPTY_DEPTH);

    logic [AWI:0] wptr_q, wptr_d;
    logic [AWO:0] rptr_q, rptr_d;
    logic         w_acc;
    logic         r_acc;
    logic [AWO:0] count_w;

    // The write pointer scaled to narrow units shares the read pointer's
    // wrap period, so a plain modular subtraction is the occupancy and the
    // extra MSB separates full from empty.
    assign count_w    = {wptr_q, {SHRINK_BIT{1'b0}}} - rptr_q;

    assign rempty     = (count_w == '0);
    // Writes are whole words: any partially drained word still occupies its
    // slot, so the threshold leaves room for exactly SHRINK units.
    assign wfull      = (count_w > FULL_LIM);
    assign prog_empty = (count_w <= PE_LIM);
    assign count      = count_w;

    assign w_acc = winc & ~wfull;
    assign r_acc = rinc & ~rempty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (r_acc) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    ramdp_shrink #(
        .AWI (AWI),
        .AWO (AWO),
        .DWI (DWI),
        .DWO (DWO)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (w_acc),
        .waddr (wptr_q[AWI-1:0]),
        .wdata (wdata),
        .re    (r_acc),
        .raddr (rptr_q[AWO-1:0]),
        .rdata (rdata)
    );

endmodule : fifo_shrink_sync

// File: tb/tb_fifo_shrink_sync.sv
module tb_fifo_shrink_sync;

    localparam int AWI = 3;
    localparam int AWO = 5;
    localparam int DWI = 16;
    localparam int DWO = 4;
    localparam int PED = 4;

    logic           clk = 1'b0;
    logic           rstn;
    logic           winc;
    logic [DWI-1:0] wdata;
    logic           rinc;
    logic [DWO-1:0] rdata;
    logic           wfull;
    logic           rempty;
    logic           prog_empty;
    logic [AWO:0]   count;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] q[$];
    logic [3:0] exp_rdata;

    always #5 clk = ~clk;

    fifo_shrink_sync #(
        .AWI              (AWI),
        .AWO              (AWO),
        .DWI              (DWI),
        .DWO              (DWO),
        .PROG_EMPTY_DEPTH (PED)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .winc       (winc),
        .wdata      (wdata),
        .rinc       (rinc),
        .rdata      (rdata),
        .wfull      (wfull),
        .rempty     (rempty),
        .prog_empty (prog_empty),
        .count      (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int n);
        logic [3:0] a0, a1, a2, a3;
        a0 = 4'(4*n);
        a1 = 4'(4*n + 1);
        a2 = 4'(4*n + 2);
        a3 = 4'(4*n + 3);
        return {a3, a2, a1, a0};
    endfunction

    // One clock with the given inputs; the queue model tracks stored units
    // and every output is compared #1 after the edge.
    task automatic cyc(input logic rn, input logic w, input logic [15:0] wd, input logic r);
        logic r_acc, w_acc;
        int   pre;
        rstn  = rn;
        winc  = w;
        wdata = wd;
        rinc  = r;
        pre   = q.size();
        r_acc = rn && r && (pre > 0);
        w_acc = rn && w && (pre <= 28);
        @(posedge clk);
        #1;
        if (!rn) begin
            q.delete();
            exp_rdata = 4'h0;
        end else begin
            if (r_acc) exp_rdata = q.pop_front();
            if (w_acc) begin
                for (int k = 0; k < 4; k++) q.push_back(wd[k*4 +: 4]);
            end
        end
        chk("m_count",      32'(count),      32'(q.size()));
        chk("m_rempty",     32'(rempty),     32'(q.size() == 0));
        chk("m_wfull",      32'(wfull),      32'(q.size() > 28));
        chk("m_prog_empty", 32'(prog_empty), 32'(q.size() <= PED));
        chk("m_rdata",      32'(rdata),      32'(exp_rdata));
    endtask

    initial begin
        logic [3:0] lane_exp [4];
        logic [3:0] sim_exp  [3];
        logic [3:0] rst_exp  [4];
        int         guard;
        int         words_sent;
        int         pops;
        int         pre;
        logic       w;

        rstn = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
        exp_rdata = 4'h0;

        // Reset state
        cyc(0, 0, 16'h0000, 0);
        cyc(0, 1, 16'hFFFF, 1);
        chk("rst_rempty", 32'(rempty), 1);
        chk("rst_wfull",  32'(wfull),  0);
        chk("rst_pe",     32'(prog_empty), 1);
        chk("rst_count",  32'(count),  0);
        chk("rst_rdata",  32'(rdata),  0);

        // Read on empty is dropped
        cyc(1, 0, 16'h0000, 1);
        chk("empty_rd_count", 32'(count), 0);
        chk("empty_rd_rdata", 32'(rdata), 0);

        // Lane order
        cyc(1, 1, 16'hA3C5, 0);
        chk("lane_cnt_w", 32'(count), 4);
        chk("lane_pe_4",  32'(prog_empty), 1);
        lane_exp = '{4'h5, 4'hC, 4'h3, 4'hA};
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 16'h0000, 1);
            chk("lane_data", 32'(rdata), 32'(lane_exp[i]));
            chk("lane_cnt",  32'(count), 32'(3 - i));
        end
        chk("lane_empty", 32'(rempty), 1);

        // Full boundary
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 16'hDCB0 + 16'(i), 0);
            chk("full_cnt", 32'(count), 32'(4*(i+1)));
            if (i == 6) chk("full_at28", 32'(wfull), 0);
        end
        chk("full_flag", 32'(wfull), 1);
        cyc(1, 1, 16'hFFFF, 0);
        chk("full_drop_cnt", 32'(count), 32);
        cyc(1, 0, 16'h0000, 1);
        chk("full_pop1_cnt", 32'(count), 31);
        chk("full_pop1_wf",  32'(wfull), 1);
        chk("full_pop1_d",   32'(rdata), 32'h0);
        cyc(1, 1, 16'hEEEE, 0);
        chk("partial_block_cnt", 32'(count), 31);
        lane_exp = '{4'hB, 4'hC, 4'hD, 4'h0};
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 16'h0000, 1);
            chk("full_pop_d", 32'(rdata), 32'(lane_exp[i]));
        end
        chk("full_28_cnt", 32'(count), 28);
        chk("full_28_wf",  32'(wfull), 0);

        // Drain to 12 (words 1..4)
        for (int i = 0; i < 16; i++) cyc(1, 0, 16'h0000, 1);
        chk("pre_sim_cnt", 32'(count), 12);

        // Simultaneous write and read
        sim_exp = '{4'h5, 4'hB, 4'hC};
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 16'hDCB8 + 16'(i), 1);
            chk("sim_cnt",  32'(count), 32'(15 + 3*i));
            chk("sim_data", 32'(rdata), 32'(sim_exp[i]));
        end

        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            cyc(1, 0, 16'h0000, 1);
            guard++;
        end
        chk("drain_empty", 32'(rempty), 1);
        chk("drain_cnt",   32'(count),  0);

        // Wrap-around stream
        words_sent = 0;
        pops = 0;
        for (int c = 0; c < 300 && (words_sent < 20 || q.size() > 0); c++) begin
            w   = (words_sent < 20);
            pre = q.size();
            cyc(1, w, pat(words_sent), 1);
            if (pre > 0) begin
                chk("wrap_data", 32'(rdata), 32'(pops % 16));
                pops++;
            end
            if (w && pre <= 28) words_sent++;
        end
        chk("wrap_units", 32'(pops), 80);
        chk("wrap_words", 32'(words_sent), 20);

        // Mid-operation reset
        for (int i = 0; i < 3; i++) cyc(1, 1, 16'h5555, 0);
        chk("mid_pre_cnt", 32'(count), 12);
        cyc(0, 1, 16'hBEEF, 1);
        chk("mid_rst_empty", 32'(rempty), 1);
        chk("mid_rst_cnt",   32'(count),  0);
        cyc(1, 1, 16'h1234, 0);
        rst_exp = '{4'h4, 4'h3, 4'h2, 4'h1};
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 16'h0000, 1);
            chk("mid_data", 32'(rdata), 32'(rst_exp[i]));
        end
        chk("mid_end_empty", 32'(rempty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo_shrink_sync

// File: doc/fifo_shrink_sync.md
# fifo_shrink_sync

Single-clock FIFO with width reduction: wide words written in, narrow words read out, least-significant lane first. It is the wide-in/narrow-out counterpart to our narrow-in/wide-out FIFO. It sits on the transmit side of serializing datapaths, feeding bit-slice engines and narrow links from a wide producer. Flow control is full/empty with a programmable almost-empty threshold.

## Interface
- AWI, 3: write address width; depth is 2^AWI wide words.
- AWO, 5: read address width; must equal AWI + log2(DWI/DWO).
- DWI, 16: write data width.
- DWO, 4: read data width; DWI must be a power-of-two multiple of DWO, at least 2×.
- PROG_EMPTY_DEPTH, 4: prog_empty threshold, in narrow units.
- clk  input  1  single clock for both ports.
- rstn  input  1  reset; synchronous, active-low.
- winc  input  1  write request.
- wdata  input  DWI  write data.
- rinc  input  1  read request.
- rdata  output  DWO  read data, registered.
- wfull  output  1  no room for one wide word.
- rempty  output  1  no narrow unit stored.
- prog_empty  output  1  stored units are at or below PROG_EMPTY_DEPTH.
- count  output  AWO+1  stored narrow units, 0..2^AWO.

## Operation
- Derived constants: SHRINK = DWI/DWO and SHRINK_BIT = AWO−AWI.
- Write pointer: wptr, AWI+1 bits, binary. Read pointer: rptr, AWO+1 bits, binary. Both wrap naturally; no Gray coding, since there is one clock.
- Accepted write = winc & !wfull. It stores wdata at wptr[AWI-1:0] and increments wptr.
- Accepted read = rinc & !rempty.
  - Word index is rptr[AWO-1:SHRINK_BIT]; lane is rptr[SHRINK_BIT-1:0].
  - rdata <= word[lane*DWO +: DWO], then rptr increments.
  - Lane 0 is wdata[DWO-1:0] and is read first.
- count = (wptr << SHRINK_BIT) − rptr, computed modulo 2^(AWO+1).
- rempty = (count == 0).
- wfull = (count > 2^AWO − SHRINK). Writes are whole-word only, so a partially drained word blocks a write until the word is fully read.
- prog_empty = (count <= PROG_EMPTY_DEPTH).
- Write while wfull and read while rempty are dropped: no pointer change, no memory change, rdata holds.
- Simultaneous accepted write and read: both take effect; count changes by +SHRINK−1.
- Status is evaluated from registered pointers, so no write-to-read bypass exists. A word cannot be read in the cycle it is written.
- No state machine. State is two pointer registers, the memory array, and the rdata register.

## Timing
- Reset (rstn low at a clk edge):
  - wptr = 0, rptr = 0, rdata = 0.
  - Outputs the following cycle: rempty = 1, wfull = 0, prog_empty = 1, count = 0.
  - Memory contents are not cleared and are unreachable.
  - A reset mid-operation discards all stored data in that single edge.
- Read latency: rdata presents the popped unit in the cycle after the accepted rinc.
- Flag latency: count, wfull, rempty and prog_empty are combinational from the pointers. They update in the cycle after the accepted operation.
- First read after a write into an empty FIFO: rempty falls one cycle after the write edge, so the earliest pop is in that cycle and data appears one cycle later.
- Wrap-around: pointer MSBs distinguish the full and empty extremes; count arithmetic stays correct across any wrap.

## Structure
- Shared package (fifo_pkg) holds:
  - functions deriving SHRINK and SHRINK_BIT;
  - the lane-order constant (LSB-first), shared with the widening FIFO so that a round trip is identity.
- One sub-module, ramdp_shrink: DWI-wide write port, DWO-wide registered read port with internal lane mux, single clock.
- The top level holds the pointers, count, and flags.

## Test plan
- Reset: drive rstn=0 for one edge from any state → rempty=1, wfull=0, prog_empty=1, count=0, rdata=0.
- Lane order: write 16'hA3C5, then pop 4 times back-to-back → rdata sequence 4'h5, 4'hC, 4'h3, 4'hA; rempty=1 after the 4th pop; count 4→0.
- Full boundary: write 8 words → count=32, wfull=1; a 9th write is ignored (count stays 32). Pop 1 → count=31, wfull=1. Pop 3 more → count=28, wfull=0.
- Simultaneous ops: at count=12, assert winc and rinc together for 3 cycles → count 15, 18, 21; read data stays in order.
- Wrap-around: stream 20 words with an incrementing pattern and continuous reads → all 80 units exact and in order, no false full or empty. prog_empty toggles at count=4/5.
- Mid-operation reset: at count=12, pulse rstn low for one edge → next cycle rempty=1, count=0; a subsequent write of 16'h1234 reads back 4, 3, 2, 1.
